// File: rtl/dmem_port.sv
// Data-memory port: latches the LSQ head request, holds word-aligned memory signals until
// mem_resp, aligns and extends load data, then pulses completion to the LSQ and the CDB.
module dmem_port #(
    parameter int TAG_W       = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lsq_read,
    input  logic             lsq_write,
    input  logic [31:0]      lsq_addr,
    input  logic [2:0]       lsq_load_type,
    input  logic [3:0]       lsq_mbe,
    input  logic [31:0]      lsq_wdata,
    input  logic [TAG_W-1:0] lsq_tag,
    input  logic             flush_ip,
    output logic             lsq_resp,
    output logic             mem_read,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [3:0]       mem_byte_enable,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_resp,
    output logic             ld_valid,
    output logic [TAG_W-1:0] ld_tag,
    output logic [31:0]      ld_data,
    output logic             timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [31:0] TMO = 32'(TIMEOUT_CYC);

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic [2:0]         f3_q, f3_d;
    logic [3:0]         mbe_q, mbe_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               load_q, load_d;
    logic               kill_q, kill_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        timer_q, timer_d;
    logic               terr_q, terr_d;

    // Misaligned halfword at offset 3 naturally sees zero in its upper byte after the shift.
    function automatic logic [31:0] align_load(input logic [31:0] rdata, input logic [1:0] off,
                                               input logic [2:0] f3);
        logic [15:0] sh;
        sh = 16'(rdata >> {off, 3'b000});
        case (f3)
            3'b000:  align_load = {{24{sh[7]}}, sh[7:0]};
            3'b001:  align_load = {{16{sh[15]}}, sh};
            3'b010:  align_load = rdata;
            3'b100:  align_load = {24'd0, sh[7:0]};
            3'b101:  align_load = {16'd0, sh};
            default: align_load = 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [31:0] wdata, input logic [2:0] f3);
        case (f3)
            3'b000:  store_data = {4{wdata[7:0]}};
            3'b001:  store_data = {2{wdata[15:0]}};
            default: store_data = wdata;
        endcase
    endfunction

    // Next-state and capture logic; inputs are only sampled in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        mbe_d   = mbe_q;
        wdata_d = wdata_q;
        tag_d   = tag_q;
        load_d  = load_q;
        kill_d  = kill_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (lsq_read || lsq_write) begin
                    state_d = S_BUSY;
                    addr_d  = lsq_addr;
                    f3_d    = lsq_load_type;
                    load_d  = lsq_read;
                    mbe_d   = lsq_read ? 4'b1111 : lsq_mbe;
                    wdata_d = store_data(lsq_wdata, lsq_load_type);
                    tag_d   = lsq_tag;
                    kill_d  = flush_ip;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (flush_ip) begin
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
                if (mem_resp) begin
                    data_d  = align_load(mem_rdata, addr_q[1:0], f3_q);
                    state_d = S_RESP;
                end else begin
                    state_d = S_BUSY;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    // Watchdog: counts BUSY cycles (saturating), flags once when the limit is reached.
    always_comb begin
        timer_d = 32'd0;
        terr_d  = terr_q;
        if ((state_q == S_BUSY) && (TMO != 32'd0)) begin
            if (timer_q != TMO) begin
                timer_d = timer_q + 32'd1;
            end else begin
                timer_d = timer_q;
            end
            if (timer_q == (TMO - 32'd1)) begin
                terr_d = 1'b1;
            end else begin
                terr_d = terr_q;
            end
        end else begin
            timer_d = 32'd0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= 32'd0;
            f3_q    <= 3'd0;
            mbe_q   <= 4'd0;
            wdata_q <= 32'd0;
            tag_q   <= '0;
            load_q  <= 1'b0;
            kill_q  <= 1'b0;
            data_q  <= 32'd0;
            timer_q <= 32'd0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            mbe_q   <= mbe_d;
            wdata_q <= wdata_d;
            tag_q   <= tag_d;
            load_q  <= load_d;
            kill_q  <= kill_d;
            data_q  <= data_d;
            timer_q <= timer_d;
            terr_q  <= terr_d;
        end
    end

    // Strobes decode straight from flops so a reset drops them at once.
    assign mem_read        = (state_q == S_BUSY) && load_q;
    assign mem_write       = (state_q == S_BUSY) && !load_q;
    assign mem_address     = {addr_q[31:2], 2'b00};
    assign mem_byte_enable = mbe_q;
    assign mem_wdata       = wdata_q;
    assign lsq_resp        = (state_q == S_RESP);
    assign ld_valid        = (state_q == S_RESP) && load_q && !kill_q && !flush_ip;
    assign ld_tag          = tag_q;
    assign ld_data         = data_q;
    assign timeout_err     = terr_q;

endmodule
